// File: rtl/cr16_pkg.sv
// Shared CR16 datapath constants and the PSR flag vector type.
// Used by the operand stage, the ALU and the branch-condition logic.
package cr16_pkg;

   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 4;
   localparam int REG_COUNT = 16;

   // Bit positions inside the {C,L,F,Z,N} flag vector
   localparam int FLAG_C = 4;
   localparam int FLAG_L = 3;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   typedef logic [4:0] flags_t;

endpackage

// File: rtl/cr16_regfile_2r1w.sv
// General register file with one synchronous write port and two asynchronous read ports.
// A synchronous active-low clear zeroes every entry and wins over a simultaneous write.
module cr16_regfile_2r1w #(
   parameter int DATA_W    = cr16_pkg::DATA_W,
   parameter int ADDR_W    = cr16_pkg::ADDR_W,
   parameter int REG_COUNT = cr16_pkg::REG_COUNT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b
);

   logic [DATA_W-1:0] regs_q [REG_COUNT];
   logic [DATA_W-1:0] regs_d [REG_COUNT];

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd_data_a = regs_q[rd_addr_a];
   assign rd_data_b = regs_q[rd_addr_b];

endmodule

// File: rtl/cr16_operand_stage.sv
// Operand-fetch / writeback stage feeding the CR16 ALU: register file, PSR and
// registered a/b operands with write-first forwarding from the writeback port.
module cr16_operand_stage
   import cr16_pkg::*;
#(
   parameter int DATA_W    = cr16_pkg::DATA_W,
   parameter int REG_COUNT = cr16_pkg::REG_COUNT,
   parameter int ADDR_W    = cr16_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              hold,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   input  logic [DATA_W-1:0] imm,
   input  logic              imm_sel,
   output logic [DATA_W-1:0] a_operand,
   output logic [DATA_W-1:0] b_operand,
   output logic              op_valid,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  flags_t            flag_we,
   input  flags_t            flags_in,
   output flags_t            psr
);

   logic [DATA_W-1:0] rd_data_a, rd_data_b;
   logic [DATA_W-1:0] fwd_a, fwd_b;
   logic [DATA_W-1:0] a_operand_d, a_operand_q;
   logic [DATA_W-1:0] b_operand_d, b_operand_q;
   logic              op_valid_d, op_valid_q;
   flags_t            psr_d, psr_q;

   cr16_regfile_2r1w #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .REG_COUNT (REG_COUNT)
   ) u_regfile (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b)
   );

   // A register being written this cycle is read as its new value
   always_comb begin
      fwd_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : rd_data_a;
      fwd_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : rd_data_b;
   end

   always_comb begin
      a_operand_d = a_operand_q;
      b_operand_d = b_operand_q;
      op_valid_d  = op_valid_q;
      psr_d       = psr_q;
      if (!hold) begin
         a_operand_d = fwd_a;
         b_operand_d = imm_sel ? imm : fwd_b;
         op_valid_d  = in_valid;
      end
      for (int i = 0; i < $bits(flags_t); i++) begin
         if (flag_we[i]) begin
            psr_d[i] = flags_in[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_operand_q <= '0;
         b_operand_q <= '0;
         op_valid_q  <= 1'b0;
         psr_q       <= '0;
      end else begin
         a_operand_q <= a_operand_d;
         b_operand_q <= b_operand_d;
         op_valid_q  <= op_valid_d;
         psr_q       <= psr_d;
      end
   end

   assign a_operand = a_operand_q;
   assign b_operand = b_operand_q;
   assign op_valid  = op_valid_q;
   assign psr       = psr_q;

endmodule

// File: doc/cr16_operand_stage.md
Name: cr16_operand_stage

Overview:
- Operand-fetch and writeback stage directly upstream of the CR16 ALU.
- Holds the 16x16 general register file and the processor status register (PSR).
- Registers the ALU aInput/bInput operands one cycle ahead of execution.
- Captures the ALU result (aluResult) and flags (C,L,F,Z,N) back into architectural state, with write-through forwarding into the operand registers.

Parameters:
- DATA_W, 16, datapath width (register, immediate, operand width).
- REG_COUNT, 16, number of general registers.
- ADDR_W, 4, register address width; must satisfy 2**ADDR_W == REG_COUNT.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  decode presents a valid operand request this cycle.
- hold  in  1  stall: freeze operand registers and op_valid.
- rd_addr_a  in  ADDR_W  source register for ALU aInput.
- rd_addr_b  in  ADDR_W  source register for ALU bInput.
- imm  in  DATA_W  immediate value from decode.
- imm_sel  in  1  1: b_operand takes imm instead of register B.
- a_operand  out  DATA_W  registered operand to ALU aInput.
- b_operand  out  DATA_W  registered operand to ALU bInput.
- op_valid  out  1  a_operand/b_operand hold a valid request.
- wr_en  in  1  write wr_data to register wr_addr.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data (ALU aluResult).
- flag_we  in  5  per-flag PSR update mask, bit order {C,L,F,Z,N}.
- flags_in  in  5  new flag values from ALU, order {C,L,F,Z,N}.
- psr  out  5  registered PSR, order {C,L,F,Z,N}.

Behaviour:
- Reset (reset==0 at a rising edge):
  - All REG_COUNT registers, a_operand, b_operand and psr clear to 0.
  - op_valid clears to 0.
  - Reset overrides wr_en, flag_we, in_valid and hold in that cycle.
  - Asserting reset mid-stall or mid-write discards the pending write.
- Register write: when wr_en=1, reg[wr_addr] <= wr_data at the edge. r0 is an ordinary writable register (no hardwired zero).
- Operand capture, when hold=0, on each edge:
  - a_operand <= fwd(rd_addr_a).
  - b_operand <= imm_sel ? imm : fwd(rd_addr_b).
  - op_valid <= in_valid.
  - fwd(x) = wr_data if (wr_en && wr_addr==x), else reg[x] (write-first forwarding).
- Operands are captured even when in_valid=0. Consumers qualify them with op_valid only.
- Stall (hold=1):
  - a_operand, b_operand and op_valid keep their values.
  - Register writes and PSR updates still occur.
  - Held operands are not refreshed by writes during the stall; the decode/hazard controller owns that hazard.
- Latency: read addresses to a_operand/b_operand is exactly 1 cycle. Writeback becomes architecturally visible on the next edge.
- Ports A and B reading the same register, both forwarded or both not, is legal and yields identical values.
- PSR: for each bit i, psr[i] <= flag_we[i] ? flags_in[i] : psr[i]. flag_we=0 leaves psr unchanged. psr is never forwarded combinationally.
- No combinational path from any input to any output. This is required so aluResult -> wr_data cannot form a loop through the ALU.
- Register array uses no reset-free storage; every entry is deterministic after reset.

Decomposition:
- Shared package cr16_pkg holds:
  - DATA_W, ADDR_W, REG_COUNT constants.
  - Flag index constants: FLAG_C=4, FLAG_L=3, FLAG_F=2, FLAG_Z=1, FLAG_N=0.
  - The 5-bit flag vector type, for reuse by the ALU, branch-condition logic and PSR.
- One sub-module, cr16_regfile_2r1w:
  - Synchronous 1-write port, 2 asynchronous read ports, synchronous active-low clear.
- Forwarding mux, immediate mux, hold logic and PSR stay in cr16_operand_stage.

Test Plan:
- Reset: preload r3=0x1234, psr=5'b10101, then reset=0 for 1 cycle -> all regs, a_operand, b_operand and psr read 0; op_valid=0.
- Basic read: write r5=0x00FF, next cycle rd_addr_a=5, rd_addr_b=5, in_valid=1 -> one cycle later a_operand=b_operand=0x00FF, op_valid=1.
- Forwarding: r7=0x0001 held; same cycle wr_en=1, wr_addr=7, wr_data=0xBEEF, rd_addr_a=7 -> a_operand=0xBEEF next edge; reading r7 later also gives 0xBEEF.
- Immediate select: rd_addr_b=2 (r2=0x1111), imm=0xFFFE, imm_sel=1 -> b_operand=0xFFFE; with imm_sel=0 -> b_operand=0x1111.
- Hold: capture a_operand=0x0042, assert hold=1 for 3 cycles while writing r1=0x9999 and changing rd_addr_a=1 -> a_operand stays 0x0042, op_valid unchanged; after hold=0 -> a_operand=0x9999.
- PSR masking: psr=0; flags_in=5'b11111, flag_we=5'b10010 -> psr=5'b10010; then flags_in=0, flag_we=5'b00010 -> psr=5'b10000.
